rs_alu: RTL and testbench

RS_ALU -- requirements
Module: rs_alu

---
 rtl/rs_alu_if.sv | 53 +++++
 rtl/rs_alu.sv | 154 +++++++++++++++
 tb/tb_rs_alu.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_alu_if.sv
// Dispatch / wakeup / issue bus of the ALU reservation station.
// master = dispatch, CDB and ALU side; slave = the reservation station.
interface rs_alu_if #(
  parameter int PHYS_REG_IDX    = 5,
  parameter int NUM_ROB_ENTRIES = 32,
  parameter int NUM_ENTRIES     = 8
);
  localparam int PR_W  = PHYS_REG_IDX + 1;
  localparam int ROB_W = $clog2(NUM_ROB_ENTRIES);
  localparam int CNT_W = $clog2(NUM_ENTRIES) + 1;

  logic             enq_valid, enq_ready;
  logic [PR_W-1:0]  enq_ps1, enq_ps2, enq_pd;
  logic             enq_rs1_rdy, enq_rs2_rdy, enq_dest_we;
  logic [31:0]      enq_imm, enq_pc;
  logic [3:0]       enq_op;
  logic [4:0]       enq_rd;
  logic [ROB_W-1:0] enq_rob_idx;
  logic [6:0]       enq_opcode;
  logic [2:0]       enq_funct3;

  logic             cdb_valid;
  logic [PR_W-1:0]  cdb_pd;
  logic             flush;

  logic             iss_valid, iss_ready;
  logic [PR_W-1:0]  iss_ps1, iss_ps2, iss_pd;
  logic [31:0]      iss_imm, iss_pc;
  logic [3:0]       iss_op;
  logic [4:0]       iss_rd;
  logic             iss_dest_we;
  logic [ROB_W-1:0] iss_rob_idx;
  logic [6:0]       iss_opcode;
  logic [2:0]       iss_funct3;

  logic [CNT_W-1:0] occupancy;

  modport master (
    output enq_valid, enq_ps1, enq_ps2, enq_rs1_rdy, enq_rs2_rdy, enq_imm, enq_op,
           enq_pd, enq_rd, enq_dest_we, enq_rob_idx, enq_pc, enq_opcode, enq_funct3,
           cdb_valid, cdb_pd, flush, iss_ready,
    input  enq_ready, iss_valid, iss_ps1, iss_ps2, iss_imm, iss_op, iss_pd, iss_rd,
           iss_dest_we, iss_rob_idx, iss_pc, iss_opcode, iss_funct3, occupancy
  );

  modport slave (
    input  enq_valid, enq_ps1, enq_ps2, enq_rs1_rdy, enq_rs2_rdy, enq_imm, enq_op,
           enq_pd, enq_rd, enq_dest_we, enq_rob_idx, enq_pc, enq_opcode, enq_funct3,
           cdb_valid, cdb_pd, flush, iss_ready,
    output enq_ready, iss_valid, iss_ps1, iss_ps2, iss_imm, iss_op, iss_pd, iss_rd,
           iss_dest_we, iss_rob_idx, iss_pc, iss_opcode, iss_funct3, occupancy
  );
endinterface

// File: rtl/rs_alu.sv
// ALU reservation station: CDB wakeup, single issue port with stable selection.
// Define RS_AGE_ORDER_EN to issue the oldest ready entry instead of the lowest-index one.
module rs_alu #(
  parameter int NUM_ENTRIES     = 8,
  parameter int PHYS_REG_IDX    = 5,
  parameter int NUM_ROB_ENTRIES = 32
) (
  input logic   clk,
  input logic   rst,
  rs_alu_if.slave rs
);
  localparam int PR_W  = PHYS_REG_IDX + 1;
  localparam int ROB_W = $clog2(NUM_ROB_ENTRIES);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [PR_W-1:0]  ps1;
    logic [PR_W-1:0]  ps2;
    logic [31:0]      imm;
    logic [3:0]       op;
    logic [PR_W-1:0]  pd;
    logic [4:0]       rd;
    logic             dest_we;
    logic [ROB_W-1:0] rob_idx;
    logic [31:0]      pc;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
  } payload_t;

  logic [NUM_ENTRIES-1:0] valid_q, rdy1_q, rdy2_q, issuable;
  payload_t               payload_q [NUM_ENTRIES];
  payload_t               enq_pl, iss_pl;
  logic                   hold_q;
  logic [IDX_W-1:0]       hold_idx_q, pick_idx, sel_idx, free_idx;
  logic                   iss_valid, enq_fire, iss_fire;
  logic                   enq_rdy1, enq_rdy2;
  logic [CNT_W-1:0]       count;

  assign issuable  = valid_q & rdy1_q & rdy2_q;
  assign iss_valid = |issuable;
  assign enq_fire  = rs.enq_valid && rs.enq_ready && !rs.flush;
  assign iss_fire  = iss_valid && rs.iss_ready && !rs.flush;

  assign enq_rdy1 = rs.enq_rs1_rdy || (rs.enq_ps1 == '0) || (rs.cdb_valid && rs.cdb_pd == rs.enq_ps1);
  assign enq_rdy2 = rs.enq_rs2_rdy || (rs.enq_ps2 == '0) || (rs.cdb_valid && rs.cdb_pd == rs.enq_ps2);

  assign enq_pl = '{ps1: rs.enq_ps1, ps2: rs.enq_ps2, imm: rs.enq_imm, op: rs.enq_op,
                    pd: rs.enq_pd, rd: rs.enq_rd, dest_we: rs.enq_dest_we,
                    rob_idx: rs.enq_rob_idx, pc: rs.enq_pc, opcode: rs.enq_opcode,
                    funct3: rs.enq_funct3};

  // NOTE: every always_comb variable gets a default first, so no path can infer a latch.
  always_comb begin
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

`ifdef RS_AGE_ORDER_EN
  localparam logic [NUM_ENTRIES-1:0] ONE = NUM_ENTRIES'(1);
  // age_q[i][j] set means entry i was enqueued before entry j.
  logic [NUM_ENTRIES-1:0] age_q [NUM_ENTRIES];

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (issuable[i] && ((issuable & ~age_q[i] & ~(ONE << i)) == '0)) pick_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q <= '{default: '0};
    end else if (enq_fire) begin
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        age_q[j][free_idx] <= (IDX_W'(j) != free_idx);
        age_q[free_idx][j] <= 1'b0;
      end
    end
  end
`else
  always_comb begin
    pick_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (issuable[i]) pick_idx = IDX_W'(i);
    end
  end
`endif

  // A stalled offer stays pinned to its entry until the ALU accepts it.
  assign sel_idx = hold_q ? hold_idx_q : pick_idx;

  // NOTE: sequential state uses non-blocking assignments so all bits update together at the edge.
  always_ff @(posedge clk) begin
    if (rst || rs.flush) begin
      valid_q    <= '0;
      rdy1_q     <= '0;
      rdy2_q     <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (valid_q[i] && rs.cdb_valid) begin
          if (rs.cdb_pd == payload_q[i].ps1 && payload_q[i].ps1 != '0) rdy1_q[i] <= 1'b1;
          if (rs.cdb_pd == payload_q[i].ps2 && payload_q[i].ps2 != '0) rdy2_q[i] <= 1'b1;
        end
      end
      if (iss_fire) begin
        valid_q[sel_idx] <= 1'b0;
        hold_q           <= 1'b0;
      end else begin
        hold_q     <= iss_valid;
        hold_idx_q <= sel_idx;
      end
      if (enq_fire) begin
        valid_q[free_idx] <= 1'b1;
        rdy1_q[free_idx]  <= enq_rdy1;
        rdy2_q[free_idx]  <= enq_rdy2;
      end
    end
  end

  // NOTE: payload storage has no reset; the valid bits alone decide whether an entry is live.
  always_ff @(posedge clk) begin
    if (enq_fire) payload_q[free_idx] <= enq_pl;
  end

  always_comb begin
    iss_pl = '0;
    if (iss_valid) iss_pl = payload_q[sel_idx];
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) count = count + CNT_W'(valid_q[i]);
  end

  assign rs.enq_ready   = ~&valid_q;
  assign rs.iss_valid   = iss_valid;
  assign rs.iss_ps1     = iss_pl.ps1;
  assign rs.iss_ps2     = iss_pl.ps2;
  assign rs.iss_imm     = iss_pl.imm;
  assign rs.iss_op      = iss_pl.op;
  assign rs.iss_pd      = iss_pl.pd;
  assign rs.iss_rd      = iss_pl.rd;
  assign rs.iss_dest_we = iss_pl.dest_we;
  assign rs.iss_rob_idx = iss_pl.rob_idx;
  assign rs.iss_pc      = iss_pl.pc;
  assign rs.iss_opcode  = iss_pl.opcode;
  assign rs.iss_funct3  = iss_pl.funct3;
  assign rs.occupancy   = count;
endmodule

// File: tb/tb_rs_alu.sv
// Self-checking bench for rs_alu: directed scenarios plus random traffic, every
// cycle compared against a slot-array model that orders entries by enqueue sequence number.
module tb_rs_alu;
  localparam int N     = 8;
  localparam int PRI   = 5;
  localparam int NROB  = 32;
  localparam int PR_W  = PRI + 1;
  localparam int ROB_W = $clog2(NROB);
  localparam int PL_W  = 3 * PR_W + 32 + 4 + 5 + 1 + ROB_W + 32 + 7 + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs_alu_if #(.PHYS_REG_IDX(PRI), .NUM_ROB_ENTRIES(NROB), .NUM_ENTRIES(N)) bus ();
  rs_alu #(.NUM_ENTRIES(N), .PHYS_REG_IDX(PRI), .NUM_ROB_ENTRIES(NROB)) dut (
    .clk(clk), .rst(rst), .rs(bus)
  );

  // Reference model: slot array, entries ranked by enqueue sequence number.
  bit              m_valid [N];
  bit              m_r1 [N];
  bit              m_r2 [N];
  logic [PR_W-1:0] m_ps1 [N];
  logic [PR_W-1:0] m_ps2 [N];
  logic [PL_W-1:0] m_pl [N];
  int unsigned     m_seq [N];
  int unsigned     seq_ctr;
  bit              m_held;
  int              m_held_idx;

  int   total, bad;
  bit   chk_en;
  logic [31:0] exp_first, exp_second;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PL_W-1:0] dut_pl();
    return {bus.iss_ps1, bus.iss_ps2, bus.iss_imm, bus.iss_op, bus.iss_pd, bus.iss_rd,
            bus.iss_dest_we, bus.iss_rob_idx, bus.iss_pc, bus.iss_opcode, bus.iss_funct3};
  endfunction

  function automatic logic [PL_W-1:0] enq_pl();
    return {bus.enq_ps1, bus.enq_ps2, bus.enq_imm, bus.enq_op, bus.enq_pd, bus.enq_rd,
            bus.enq_dest_we, bus.enq_rob_idx, bus.enq_pc, bus.enq_opcode, bus.enq_funct3};
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic int m_pick();
    int best = -1;
    if (m_held) return m_held_idx;
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && m_r1[i] && m_r2[i]) begin
`ifdef RS_AGE_ORDER_EN
        if (best < 0 || m_seq[i] < m_seq[best]) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  // Compare outputs against the model, advance the model with the current inputs, then clock.
  task automatic tick();
    int sel, fr;
    bit iv, er;
    logic [PL_W-1:0] exp_pl;
    sel = m_pick();
    iv  = (sel >= 0);
    fr  = m_free();
    er  = (fr >= 0);
    exp_pl = '0;
    if (iv) exp_pl = m_pl[sel];
    if (chk_en) begin
      check("enq_ready", 128'(bus.enq_ready), 128'(er));
      check("iss_valid", 128'(bus.iss_valid), 128'(iv));
      check("occupancy", 128'(bus.occupancy), 128'(m_count()));
      check("iss_payload", 128'(dut_pl()), 128'(exp_pl));
    end
    if (rst || bus.flush) begin
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      m_held = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_valid[i] && bus.cdb_valid) begin
          if (bus.cdb_pd == m_ps1[i] && m_ps1[i] != 0) m_r1[i] = 1'b1;
          if (bus.cdb_pd == m_ps2[i] && m_ps2[i] != 0) m_r2[i] = 1'b1;
        end
      end
      if (iv && bus.iss_ready) begin
        m_valid[sel] = 1'b0;
        m_held = 1'b0;
      end else begin
        m_held = iv;
        m_held_idx = sel;
      end
      if (bus.enq_valid && er) begin
        m_valid[fr] = 1'b1;
        m_ps1[fr]   = bus.enq_ps1;
        m_ps2[fr]   = bus.enq_ps2;
        m_r1[fr]    = bus.enq_rs1_rdy || bus.enq_ps1 == 0 || (bus.cdb_valid && bus.cdb_pd == bus.enq_ps1);
        m_r2[fr]    = bus.enq_rs2_rdy || bus.enq_ps2 == 0 || (bus.cdb_valid && bus.cdb_pd == bus.enq_ps2);
        m_pl[fr]    = enq_pl();
        m_seq[fr]   = seq_ctr;
        seq_ctr++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0;
    bus.enq_valid = 1'b0;  bus.enq_ps1 = '0;  bus.enq_ps2 = '0;
    bus.enq_rs1_rdy = 1'b0; bus.enq_rs2_rdy = 1'b0;
    bus.enq_imm = '0;  bus.enq_op = '0;  bus.enq_pd = '0;  bus.enq_rd = '0;
    bus.enq_dest_we = 1'b0;  bus.enq_rob_idx = '0;  bus.enq_pc = '0;
    bus.enq_opcode = '0;  bus.enq_funct3 = '0;
    bus.cdb_valid = 1'b0;  bus.cdb_pd = '0;  bus.flush = 1'b0;  bus.iss_ready = 1'b0;
  endtask

  task automatic set_enq(input logic [31:0] pc, input int ps1, input bit r1, input int ps2, input bit r2);
    bus.enq_valid   = 1'b1;
    bus.enq_pc      = pc;
    bus.enq_ps1     = PR_W'(ps1);
    bus.enq_rs1_rdy = r1;
    bus.enq_ps2     = PR_W'(ps2);
    bus.enq_rs2_rdy = r2;
    bus.enq_imm     = $urandom;
    bus.enq_op      = 4'($urandom);
    bus.enq_pd      = PR_W'($urandom);
    bus.enq_rd      = 5'($urandom);
    bus.enq_dest_we = 1'($urandom);
    bus.enq_rob_idx = ROB_W'($urandom);
    bus.enq_opcode  = 7'($urandom);
    bus.enq_funct3  = 3'($urandom);
  endtask

  initial begin
    total = 0; bad = 0; chk_en = 1'b0; seq_ctr = 0; m_held = 1'b0; m_held_idx = 0;
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    idle();
    rst = 1'b1;
    @(negedge clk);
    tick();
    tick();
    idle();
    chk_en = 1'b1;
    check("rst_enq_ready", 128'(bus.enq_ready), 128'(1));
    check("rst_iss_valid", 128'(bus.iss_valid), 128'(0));
    check("rst_occupancy", 128'(bus.occupancy), 128'(0));
    check("rst_payload", 128'(dut_pl()), 128'(0));

    // CDB wakeup of the second source: issue exactly one cycle after the broadcast edge.
    set_enq(32'h100, 5, 1'b1, 6, 1'b0); tick();
    idle(); bus.cdb_valid = 1'b1; bus.cdb_pd = 6;
    check("wake_not_yet", 128'(bus.iss_valid), 128'(0));
    tick();
    idle();
    check("wake_iss_valid", 128'(bus.iss_valid), 128'(1));
    check("wake_iss_ps2", 128'(bus.iss_ps2), 128'(6));
    check("wake_iss_pc", 128'(bus.iss_pc), 128'(32'h100));
    bus.iss_ready = 1'b1; tick(); idle();
    check("wake_drained", 128'(bus.occupancy), 128'(0));

    // Broadcast in the same cycle as dispatch makes the entry ready immediately.
    set_enq(32'h200, 0, 1'b0, 9, 1'b0); bus.cdb_valid = 1'b1; bus.cdb_pd = 9; tick();
    idle();
    check("bypass_iss_valid", 128'(bus.iss_valid), 128'(1));
    check("bypass_iss_ps2", 128'(bus.iss_ps2), 128'(9));
    bus.iss_ready = 1'b1; tick(); idle();

    // Fill all entries, then one handshake frees a slot for the following cycle.
    for (int i = 0; i < N; i++) begin
      set_enq(32'h300 + 32'(i), 0, 1'b1, 0, 1'b1); tick();
    end
    idle();
    check("full_enq_ready", 128'(bus.enq_ready), 128'(0));
    check("full_occupancy", 128'(bus.occupancy), 128'(8));
    check("full_iss_pc", 128'(bus.iss_pc), 128'(32'h300));
    bus.iss_ready = 1'b1; tick(); idle();
    check("after_pop_enq_ready", 128'(bus.enq_ready), 128'(1));
    check("after_pop_occupancy", 128'(bus.occupancy), 128'(7));
    bus.flush = 1'b1; tick(); idle();
    check("flush_occupancy", 128'(bus.occupancy), 128'(0));

    // Age order: A in slot 3 is older than B reusing slot 0; both wake on the same tag.
    set_enq(32'h400, 0, 1'b1, 0, 1'b1);  tick();
    set_enq(32'h401, 20, 1'b0, 0, 1'b1); tick();
    set_enq(32'h402, 21, 1'b0, 0, 1'b1); tick();
    set_enq(32'h4A0, 30, 1'b0, 0, 1'b1); tick();
    idle(); bus.iss_ready = 1'b1; tick();
    idle(); set_enq(32'h4B0, 30, 1'b0, 0, 1'b1); tick();
    idle(); bus.cdb_valid = 1'b1; bus.cdb_pd = 30; tick();
    idle();
    exp_first = 32'h4B0; exp_second = 32'h4A0;
`ifdef RS_AGE_ORDER_EN
    exp_first = 32'h4A0; exp_second = 32'h4B0;
`endif
    check("order_occupancy", 128'(bus.occupancy), 128'(4));
    check("order_first", 128'(bus.iss_pc), 128'(exp_first));
    bus.iss_ready = 1'b1; tick(); idle();
    check("order_second", 128'(bus.iss_pc), 128'(exp_second));
    bus.flush = 1'b1; tick(); idle();

    // Flush beats a same-cycle enqueue and issue handshake.
    set_enq(32'h500, 0, 1'b1, 0, 1'b1); tick();
    set_enq(32'h501, 0, 1'b1, 0, 1'b1); bus.iss_ready = 1'b1; bus.flush = 1'b1;
    check("flush_pre_valid", 128'(bus.iss_valid), 128'(1));
    tick(); idle();
    check("flush_post_occupancy", 128'(bus.occupancy), 128'(0));
    check("flush_post_valid", 128'(bus.iss_valid), 128'(0));
    bus.iss_ready = 1'b1; tick(); tick();
    check("flushed_never_issues", 128'(bus.iss_valid), 128'(0));
    idle();

    // A stalled offer holds its payload while a lower-index entry wakes up.
    set_enq(32'h600, 40, 1'b0, 0, 1'b1); tick();
    set_enq(32'h601, 0, 1'b1, 0, 1'b1);  tick();
    idle();
    check("stall_first_pc", 128'(bus.iss_pc), 128'(32'h601));
    bus.cdb_valid = 1'b1; bus.cdb_pd = 40;
    for (int c = 0; c < 4; c++) begin
      tick();
      bus.cdb_valid = 1'b0;
      check("stall_hold_pc", 128'(bus.iss_pc), 128'(32'h601));
      check("stall_hold_ps1", 128'(bus.iss_ps1), 128'(0));
    end
    bus.iss_ready = 1'b1; tick(); idle();
    check("stall_next_pc", 128'(bus.iss_pc), 128'(32'h600));
    bus.iss_ready = 1'b1; tick(); idle();

    // Random traffic against the model, alternating drain-heavy and fill-heavy phases.
    for (int c = 0; c < 800; c++) begin
      idle();
      if ($urandom_range(0, 3) != 0)
        set_enq($urandom, int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
      bus.cdb_valid = 1'($urandom);
      bus.cdb_pd    = PR_W'($urandom_range(0, 7));
      bus.iss_ready = ((c % 100) < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 59) == 0);
      rst           = ($urandom_range(0, 199) == 0);
      tick();
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
